// File: rtl/cpu_pkg.sv
// cpu_pkg: loader state encoding, instruction width and byte order shared with the CPU side
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam bit HI_FIRST = 1'b1;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR} ld_state_t;
  function automatic logic [INSTR_W-1:0] join_bytes(input logic [7:0] a, input logic [7:0] b);
    return HI_FIRST ? {a, b} : {b, a};
  endfunction
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte idle watchdog, reloads on clr and flags expiry after TIMEOUT_CYCLES idle cycles (0 = never)
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [W-1:0] INIT = W'(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  // reload on clear, otherwise count down while a frame is in progress
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= INIT;
    else if (clr) cnt <= INIT;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign expire = (TIMEOUT_CYCLES != 0) && en && !clr && cnt == W'(1);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot loader turning a length-prefixed byte stream into imem writes; LOADER_CHECKSUM_EN adds a trailing XOR byte check
import cpu_pkg::*;
module prog_loader #(
  parameter int ADDR_W = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_run,
  output logic               load_err,
  output logic [ADDR_W:0]    words_loaded
);
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t FIN = CSUM;
  logic [7:0] csum;
`else
  localparam ld_state_t FIN = DONE;
`endif
  ld_state_t state;
  logic [7:0] len_hi, hi;
  logic [ADDR_W:0] len, wl_next;
  logic [ADDR_W-1:0] addr;
  logic [15:0] n_rx;
  logic xfer, tmo_en, tmo_clr, expire;
  assign xfer = rx_valid && rx_ready;
  assign n_rx = {len_hi, rx_data};
  assign wl_next = words_loaded + (ADDR_W+1)'(1);
  assign tmo_en = state inside {LEN_LO, DATA_HI, DATA_LO, CSUM};
  assign tmo_clr = reload || xfer || !tmo_en;
  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk), .rst_n(rst_n), .clr(tmo_clr), .en(tmo_en), .expire(expire)
  );
  // frame FSM with registered write port, handshake and status outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LEN_HI;
      rx_ready <= 1'b0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      cpu_run <= 1'b0;
      load_err <= 1'b0;
      words_loaded <= '0;
      addr <= '0;
      len <= '0;
      len_hi <= '0;
      hi <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        state <= LEN_HI;
        rx_ready <= 1'b1;
        cpu_run <= 1'b0;
        load_err <= 1'b0;
        words_loaded <= '0;
        addr <= '0;
      end else if (expire) begin
        state <= ERR;
        rx_ready <= 1'b0;
        load_err <= 1'b1;
      end else begin
        case (state)
          LEN_HI: begin
            rx_ready <= 1'b1;
            if (xfer) begin
              len_hi <= rx_data;
              state <= LEN_LO;
            end
          end
          LEN_LO: if (xfer) begin
            if (32'(n_rx) > 32'(CAP)) begin
              state <= ERR;
              rx_ready <= 1'b0;
              load_err <= 1'b1;
            end else if (n_rx == '0) begin
              state <= FIN;
              rx_ready <= FIN != DONE;
              cpu_run <= FIN == DONE;
            end else begin
              len <= (ADDR_W+1)'(n_rx);
              addr <= '0;
              words_loaded <= '0;
              state <= DATA_HI;
            end
          end
          DATA_HI: if (xfer) begin
            hi <= rx_data;
            state <= DATA_LO;
          end
          DATA_LO: if (xfer) begin
            imem_we <= 1'b1;
            imem_addr <= addr;
            imem_wdata <= join_bytes(hi, rx_data);
            addr <= addr + ADDR_W'(1);
            words_loaded <= wl_next;
            state <= wl_next == len ? FIN : DATA_HI;
            rx_ready <= !(wl_next == len && FIN == DONE);
          end
`ifdef LOADER_CHECKSUM_EN
          CSUM: if (xfer) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state <= DONE;
              cpu_run <= 1'b1;
            end else begin
              state <= ERR;
              load_err <= 1'b1;
            end
          end
`endif
          DONE: cpu_run <= 1'b1;
          default: ;
        endcase
      end
`ifdef LOADER_CHECKSUM_EN
      if (reload) csum <= '0;
      else if (xfer && state != CSUM) csum <= csum ^ rx_data;
`endif
    end
endmodule
